uart_byte_receiver: RTL and testbench



---
 rtl/uart_byte_receiver.sv | 198 +++++++++++++++++++
 tb/tb_uart_byte_receiver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with mid-bit sampling, valid/ready
// output handshake and sticky framing/overrun error flag.
// Optional even parity (8E1 frames) when UART_RX_EVEN_PARITY_EN is defined.
module uart_byte_receiver #(
    parameter int CLOCK_RATE = 48000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       valid,
    input  logic       ready,
    output logic       err
);

    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Counters count down to zero, so they are loaded with (period - 1).
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);

`ifdef UART_RX_EVEN_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       out_reg, out_next;
    logic             valid_reg, valid_next;
    logic             err_reg, err_next;
    logic [1:0]       sync_reg;
    logic             rx_s;
    logic             cnt_zero;
    logic             byte_ok;

`ifdef UART_RX_EVEN_PARITY_EN
    logic             parity_bad_reg, parity_bad_next;
`endif

    assign rx_s     = sync_reg[1];
    assign cnt_zero = (cnt_reg == '0);

`ifdef UART_RX_EVEN_PARITY_EN
    assign byte_ok = rx_s && !parity_bad_reg;
`else
    assign byte_ok = rx_s;
`endif

    assign out   = out_reg;
    assign valid = valid_reg;
    assign err   = err_reg;

    // Two-flop synchronizer; preset high so a line held low across reset
    // does not look like a fresh start bit at the instant reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], in};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            out_reg        <= '0;
            valid_reg      <= 1'b0;
            err_reg        <= 1'b0;
`ifdef UART_RX_EVEN_PARITY_EN
            parity_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            out_reg        <= out_next;
            valid_reg      <= valid_next;
            err_reg        <= err_next;
`ifdef UART_RX_EVEN_PARITY_EN
            parity_bad_reg <= parity_bad_next;
`endif
        end
    end

    // Next-state logic: frame sequencing, byte delivery, handshake and errors.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        out_next        = out_reg;
        valid_next      = valid_reg;
        err_next        = err_reg;
`ifdef UART_RX_EVEN_PARITY_EN
        parity_bad_next = parity_bad_reg;
`endif

        // Consumption works regardless of enable; a byte completing on the
        // same edge overrides this below.
        if (valid_reg && ready) begin
            valid_next = 1'b0;
        end

        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        bit_cnt_next = '0;
                        cnt_next     = HALF_LOAD;
                        state_next   = START;
                    end
                end

                START: begin
                    if (cnt_zero) begin
                        if (!rx_s) begin
                            // Confirmed start bit: a new frame begins, so the
                            // sticky error from earlier frames is dropped.
                            err_next   = 1'b0;
                            cnt_next   = BIT_LOAD;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_zero) begin
                        shift_next   = {rx_s, shift_reg[7:1]};
                        cnt_next     = BIT_LOAD;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_EVEN_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end

`ifdef UART_RX_EVEN_PARITY_EN
                PARITY: begin
                    if (cnt_zero) begin
                        parity_bad_next = rx_s ^ (^shift_reg);
                        cnt_next        = BIT_LOAD;
                        state_next      = STOP;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt_zero) begin
                        state_next = IDLE;
                        if (byte_ok) begin
                            out_next   = shift_reg;
                            valid_next = 1'b1;
                            if (valid_reg && !ready) begin
                                err_next = 1'b1;
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: directed frames on the RX line, checked every cycle
// against an event-time model of the receiver plus literal spot checks.
module tb_uart_byte_receiver;

    localparam int CLOCK_RATE = 48000000;
    localparam int BAUD_RATE  = 115200;
    localparam int CPB        = CLOCK_RATE / BAUD_RATE;
    localparam int HALF       = CPB / 2;
`ifdef UART_RX_EVEN_PARITY_EN
    localparam int LAT        = 2 + HALF + 10 * CPB;
    localparam int LAT_LIT    = 4370;
`else
    localparam int LAT        = 2 + HALF + 9 * CPB;
    localparam int LAT_LIT    = 3954;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b1;
    logic       in    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] out;
    logic       valid;
    logic       err;

    uart_byte_receiver #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .in   (in),
        .out  (out),
        .valid(valid),
        .ready(ready),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Frame table written by the stimulus, consumed by the model.
    int         fr_t0   [0:31];
    logic [7:0] fr_byte [0:31];
    logic       fr_ok   [0:31];
    int         n_sent = 0;

    // Model state.
    int         cyc     = 0;
    int         m_idx   = 0;
    logic [7:0] m_out   = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;

    int         vectors     = 0;
    int         miscompares = 0;
    int         fail_lines  = 0;
    logic       prev_valid  = 1'b0;
    int         last_rise   = -1;
    logic [7:0] rise_byte   = 8'h00;

    // Model: a frame whose start edge is t0 confirms its start at t0+2+HALF
    // and delivers (or flags) its byte at t0+LAT; reset or en=0 abandons it.
    always @(posedge clk) begin : model
        int         e;
        int         k;
        logic       nv;
        logic       ne;
        logic [7:0] no;
        e  = cyc + 1;
        k  = m_idx;
        nv = m_valid;
        ne = m_err;
        no = m_out;
        if (reset) begin
            nv = 1'b0;
            ne = 1'b0;
            no = 8'h00;
            if (k < n_sent && fr_t0[k] <= e) k = k + 1;
        end else begin
            if (m_valid && ready) nv = 1'b0;
            if (k < n_sent) begin
                if (!en) begin
                    if (fr_t0[k] <= e) k = k + 1;
                end else begin
                    if (e == fr_t0[k] + 2 + HALF) ne = 1'b0;
                    if (e == fr_t0[k] + LAT) begin
                        if (fr_ok[k]) begin
                            no = fr_byte[k];
                            if (m_valid && !ready) ne = 1'b1;
                            nv = 1'b1;
                        end else begin
                            ne = 1'b1;
                        end
                        k = k + 1;
                    end
                end
            end
        end
        cyc     <= e;
        m_idx   <= k;
        m_valid <= nv;
        m_err   <= ne;
        m_out   <= no;
    end

    // Cycles within the accepted latency tolerance of a model event.
    function automatic bit near_evt(input int c);
        for (int k = 0; k < n_sent; k++) begin
            int tc;
            int td;
            tc = fr_t0[k] + 2 + HALF;
            td = fr_t0[k] + LAT;
            if ((c >= tc - 2 && c <= tc + 2) || (c >= td - 2 && c <= td + 2)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance n cycles, comparing DUT outputs with the model on each one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid === 1'b1 && prev_valid !== 1'b1) begin
                last_rise = cyc;
                rise_byte = out;
            end
            prev_valid = valid;
            if (!near_evt(cyc)) begin
                vectors++;
                if (out !== m_out || valid !== m_valid || err !== m_err) begin
                    miscompares++;
                    if (fail_lines < 20) begin
                        fail_lines++;
                        $display("FAIL model cycle %0d: out=%02h valid=%b err=%b, required out=%02h valid=%b err=%b",
                                 cyc, out, valid, err, m_out, m_valid, m_err);
                    end
                end
            end
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // Drive a frame: start bit, nbits data bits LSB first; a full frame
    // (nbits == 8) also gets parity (if enabled) and the given stop bit.
    task automatic send(input logic [7:0] b, input logic stop_bit, input int nbits);
        int k;
        k          = n_sent;
        fr_t0[k]   = cyc + 1;
        fr_byte[k] = b;
        fr_ok[k]   = stop_bit;
        n_sent     = k + 1;
        in = 1'b0;
        tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            in = b[i];
            tick(CPB);
        end
        if (nbits == 8) begin
`ifdef UART_RX_EVEN_PARITY_EN
            in = ^b;
            tick(CPB);
`endif
            in = stop_bit;
            tick(CPB);
            in = 1'b1;
        end
    endtask

    task automatic consume();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    initial begin
        int t0;
        int lat;

        tick(4);
        chk8("reset out", out, 8'h00);
        chk1("reset valid", valid, 1'b0);
        chk1("reset err", err, 1'b0);
        reset = 1'b0;
        tick(20);

        // 0x30 held with ready low, then consumed.
        t0 = cyc + 1;
        send(8'h30, 1'b1, 8);
        lat = last_rise - t0;
        vectors++;
        if (lat < LAT_LIT - 2 || lat > LAT_LIT + 2) begin
            miscompares++;
            $display("FAIL latency 0x30: got %0d cycles, required %0d +/-2", lat, LAT_LIT);
        end
        tick(1000);
        chk8("0x30 held out", out, 8'h30);
        chk1("0x30 held valid", valid, 1'b1);
        consume();
        chk1("0x30 consumed valid", valid, 1'b0);
        chk8("0x30 consumed out", out, 8'h30);
        chk1("0x30 consumed err", err, 1'b0);
        tick(20);

        // Back-to-back 0x55, 0xAA with ready high.
        ready = 1'b1;
        send(8'h55, 1'b1, 8);
        chk8("0x55 delivered", rise_byte, 8'h55);
        send(8'hAA, 1'b1, 8);
        tick(20);
        chk8("0xAA delivered", rise_byte, 8'hAA);
        chk8("b2b out", out, 8'hAA);
        chk1("b2b valid", valid, 1'b0);
        chk1("b2b err", err, 1'b0);
        ready = 1'b0;

        // Framing error on 0x41, recovery with 0x42.
        send(8'h41, 1'b0, 8);
        tick(600);
        chk1("framing err", err, 1'b1);
        chk1("framing valid", valid, 1'b0);
        chk8("framing out kept", out, 8'hAA);
        send(8'h42, 1'b1, 8);
        tick(20);
        chk8("0x42 out", out, 8'h42);
        chk1("0x42 valid", valid, 1'b1);
        chk1("0x42 err cleared", err, 1'b0);
        consume();

        // 100-cycle glitch, then 0x20.
        in = 1'b0;
        tick(100);
        in = 1'b1;
        tick(400);
        chk1("glitch valid", valid, 1'b0);
        chk1("glitch err", err, 1'b0);
        send(8'h20, 1'b1, 8);
        tick(20);
        chk8("0x20 out", out, 8'h20);
        chk1("0x20 valid", valid, 1'b1);
        chk1("0x20 err", err, 1'b0);
        consume();
        tick(5);

        // Overrun: 0x31 then 0x32 with ready low.
        send(8'h31, 1'b1, 8);
        send(8'h32, 1'b1, 8);
        tick(20);
        chk8("overrun out", out, 8'h32);
        chk1("overrun valid", valid, 1'b1);
        chk1("overrun err", err, 1'b1);
        consume();
        tick(5);

        // Reset mid-frame after bit 3, then 0x7E.
        send(8'h5A, 1'b1, 4);
        reset = 1'b1;
        in    = 1'b1;
        tick(3);
        chk8("midreset out", out, 8'h00);
        chk1("midreset valid", valid, 1'b0);
        chk1("midreset err", err, 1'b0);
        reset = 1'b0;
        tick(500);
        chk1("after reset no byte", valid, 1'b0);
        send(8'h7E, 1'b1, 8);
        tick(20);
        chk8("0x7E out", out, 8'h7E);
        chk1("0x7E valid", valid, 1'b1);
        chk1("0x7E err", err, 1'b0);
        consume();

        // Enable dropped mid-frame, then 0x3C; consumption while disabled.
        send(8'h99, 1'b1, 4);
        en = 1'b0;
        in = 1'b1;
        tick(50);
        chk1("en drop valid", valid, 1'b0);
        chk8("en drop out kept", out, 8'h7E);
        en = 1'b1;
        tick(500);
        chk1("after en no byte", valid, 1'b0);
        send(8'h3C, 1'b1, 8);
        tick(20);
        chk8("0x3C out", out, 8'h3C);
        chk1("0x3C valid", valid, 1'b1);
        en = 1'b0;
        consume();
        chk1("consume while disabled", valid, 1'b0);
        chk8("disabled out kept", out, 8'h3C);
        en = 1'b1;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
